// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// master drives requests; slave is the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             v;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, v
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, v
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/sub using one 4-bit carry-lookahead slice, LS nibble first.
// Optional: define NIBBLE_SERIAL_ADDER_SAT_EN to saturate result on signed overflow.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             v_q;

    logic [3:0] na;
    logic [3:0] nb;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] sum;
    logic [WIDTH-1:0] sat_val;

    // Lookahead slice on the nibble currently selected by idx
    always_comb begin
        na   = 4'(opa >> {idx, 2'b00});
        nb   = 4'(opb >> {idx, 2'b00});
        p    = na ^ nb;
        g    = na & nb;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        sat_val = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res_q[{idx, 2'b00} +: 4] <= sum;
                    carry <= c[4];
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
                        // Whole word overwritten so lower nibbles match the clamp value
                        if (c[4] ^ c[3]) res_q <= sat_val;
`endif
                        cout_q <= c[4];
                        v_q    <= c[4] ^ c[3];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.v      = v_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed table, handshake corner cases,
// and random passes at WIDTH=16 and WIDTH=32.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(16)) if16 ();
    nibble_serial_adder_if #(.WIDTH(32)) if32 ();

    nibble_serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    nibble_serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[10];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Arithmetic reference: a + (sub ? ~b+1 : b) over w bits
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input int unsigned w, output logic [31:0] r,
                                  output logic c, output logic ov);
        logic [63:0] mask, bx, full, ae;
        ae   = {32'd0, a};
        mask = (64'd1 << w) - 64'd1;
        bx   = s ? (~{32'd0, b}) & mask : {32'd0, b};
        full = ae + bx + 64'(s);
        r    = 32'(full & mask);
        c    = full[w];
        ov   = (ae[w-1] == bx[w-1]) && (full[w-1] != ae[w-1]);
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
        if (ov) r = ae[w-1] ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
`endif
    endfunction

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [15:0] r, output logic c, output logic ov, output int lat);
        @(negedge clk);
        if16.start = 1'b1; if16.a = a; if16.b = b; if16.sub = s;
        @(negedge clk);
        if16.start = 1'b0;
        lat = 1;
        while (!if16.done && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        if (!if16.done) begin
            errors++; checks++;
            $display("FAIL op16_timeout: got no done expected done within 20 cycles");
        end
        r = if16.result; c = if16.cout; ov = if16.v;
        @(negedge clk);
        chk("op16_done_width", 32'(if16.done), 32'd0);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] r, output logic c, output logic ov, output int lat);
        @(negedge clk);
        if32.start = 1'b1; if32.a = a; if32.b = b; if32.sub = s;
        @(negedge clk);
        if32.start = 1'b0;
        lat = 1;
        while (!if32.done && lat <= 30) begin
            @(negedge clk);
            lat++;
        end
        if (!if32.done) begin
            errors++; checks++;
            $display("FAIL op32_timeout: got no done expected done within 30 cycles");
        end
        r = if32.result; c = if32.cout; ov = if32.v;
        @(negedge clk);
        chk("op32_done_width", 32'(if32.done), 32'd0);
    endtask

    initial begin
        logic [15:0] r16;
        logic [31:0] r32, er;
        logic c, ov, ec, ev;
        int lat;

        if16.start = 1'b0; if16.sub = 1'b0; if16.a = '0; if16.b = '0;
        if32.start = 1'b0; if32.sub = 1'b0; if32.a = '0; if32.b = '0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
        vecs[2].r = 16'h7FFF;
        vecs[4].r = 16'h8000;
        vecs[7].r = 16'h8000;
`endif

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(if16.busy), 32'd0);
        chk("rst_done", 32'(if16.done), 32'd0);
        chk("rst_result", 32'(if16.result), 32'd0);
        chk("rst_cout", 32'(if16.cout), 32'd0);
        chk("rst_v", 32'(if16.v), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            op16(vecs[i].a, vecs[i].b, vecs[i].sub, r16, c, ov, lat);
            chk($sformatf("vec%0d_result", i), 32'(r16), 32'(vecs[i].r));
            chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].c));
            chk($sformatf("vec%0d_v", i), 32'(ov), 32'(vecs[i].v));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
        end

        // start held through RUN with operands changing, then re-accepted in DONE
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'h1111; if16.b = 16'h2222; if16.sub = 1'b0;
        @(negedge clk);
        if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.sub = 1'b1;
        chk("hold_busy", 32'(if16.busy), 32'd1);
        lat = 1;
        while (!if16.done && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_latency", 32'(lat), 32'd5);
        chk("hold_result", 32'(if16.result), 32'h3333);
        if16.a = 16'h0001; if16.b = 16'h0001; if16.sub = 1'b0;
        @(negedge clk);
        if16.start = 1'b0;
        chk("b2b_busy", 32'(if16.busy), 32'd1);
        lat = 1;
        while (!if16.done && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_spacing", 32'(lat), 32'd5);
        chk("b2b_result", 32'(if16.result), 32'h0002);
        @(negedge clk);
        chk("b2b_done_width", 32'(if16.done), 32'd0);

        // asynchronous reset between E2 and E3
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'h1234; if16.b = 16'h4321; if16.sub = 1'b0;
        @(negedge clk);
        if16.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(if16.busy), 32'd0);
        chk("arst_done", 32'(if16.done), 32'd0);
        chk("arst_result", 32'(if16.result), 32'd0);
        chk("arst_cout", 32'(if16.cout), 32'd0);
        chk("arst_v", 32'(if16.v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op16(16'h00FF, 16'h0001, 1'b0, r16, c, ov, lat);
        chk("post_rst_result", 32'(r16), 32'h0100);
        chk("post_rst_cout", 32'(c), 32'd0);
        chk("post_rst_v", 32'(ov), 32'd0);
        chk("post_rst_latency", 32'(lat), 32'd5);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic rs;
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (i < 8) begin
                ra = (i[0]) ? 32'h0000_FFFF : 32'h0000_7FFF;
                rb = (i[1]) ? 32'h0000_8000 : 32'h0000_0001;
            end
            model({16'd0, ra[15:0]}, {16'd0, rb[15:0]}, rs, 16, er, ec, ev);
            op16(ra[15:0], rb[15:0], rs, r16, c, ov, lat);
            chk("rnd16_result", 32'(r16), er);
            chk("rnd16_cout", 32'(c), 32'(ec));
            chk("rnd16_v", 32'(ov), 32'(ev));
            chk("rnd16_latency", 32'(lat), 32'd5);
        end

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic rs;
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, 32, er, ec, ev);
            op32(ra, rb, rs, r32, c, ov, lat);
            chk("rnd32_result", r32, er);
            chk("rnd32_cout", 32'(c), 32'(ec));
            chk("rnd32_v", 32'(ov), 32'(ev));
            chk("rnd32_latency", 32'(lat), 32'd9);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor for the ODE datapath.
- Feeds a 4-bit carry-lookahead slice one nibble per cycle, least significant nibble first, and registers the slice carry between cycles.
- Trades throughput for area in the solver's step/accumulate path.
- Provides a start/busy/done handshake, plus final carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8. N = WIDTH/4 slices.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A (two's complement); sampled with start.
- b  input  WIDTH  operand B (two's complement); sampled with start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse; result/cout/v valid.
- result  output  WIDTH  sum/difference.
- cout  output  1  final carry-out; for subtraction, 1 = no borrow.
- v  output  1  signed overflow, equal to carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, at any time including mid-operation):
  - state=IDLE; busy, done, result, cout, v and the internal carry/index/operand registers are all 0.
  - Any in-flight operation is abandoned.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1; lasts exactly one cycle.
- Accept (edge E0, state IDLE or DONE, start=1):
  - latch opA=a, opB = sub ? ~b : b, carry=sub, idx=0.
  - go to RUN.
- RUN edge Ek (k=1..N) processes nibble idx=k-1 through the slice:
  - p = opA_nib ^ opB_nib; g = opA_nib & opB_nib; lookahead carries c0..c4 with c0 = carry.
  - result[4*idx+3 : 4*idx] <= p ^ c[3:0].
  - carry <= c4; idx <= idx+1.
- On edge EN (last nibble):
  - cout <= c4; v <= c4 ^ c3; go to DONE.
- Latency: done is high in the cycle after edge E0+N (N=4 for WIDTH=16). Throughput is one operation per N+1 cycles.
- result, cout, v hold their last values through IDLE and DONE. During RUN, result is partially updated and not valid.
- start=1 while busy=1 is ignored; a, b and sub changes during RUN have no effect.
- start=1 during the DONE cycle is accepted: done still pulses that cycle, and the next cycle is RUN.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is reported only via v.
- Zero-crossing / all-ones operands need no special handling; carry propagates across all nibbles.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SAT_EN.
- Defined: on the final edge, if the signed overflow condition is true, result is written as the saturated value instead of the wrapped value.
  - Positive overflow (MSB of opA=0) gives 0x7F..F; negative overflow gives 0x80..0.
  - v is still reported as 1; cout is unchanged (raw carry).
  - The MSB nibble write uses the saturated value; lower nibbles are overwritten at the same final edge.
- Not defined: result is always the wrapped modulo-2^WIDTH value.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, sub=0, start 1 cycle -> busy for 4 cycles, done pulse in 5th cycle after E0, result=0x5555, cout=0, v=0.
- a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, v=0. a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, v=1. With SAT_EN defined, the second case gives result=0x7FFF, v=1.
- Subtraction:
  - a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, v=0.
  - a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, v=1; with SAT_EN -> 0x8000.
- start held high and operands changed during RUN -> no restart, result of the original operands. Then start asserted in the DONE cycle with a=0x0001, b=0x0001 -> the second done comes exactly N+1 cycles after the first, result=0x0002.
- rst_n pulled low asynchronously between E2 and E3 of an operation -> busy/done/result/cout/v read 0 immediately and state=IDLE. After release, a fresh 0x00FF+0x0001 gives 0x0100, cout=0, v=0.
- Randomized pass of ≥1000 operations, WIDTH=16 and WIDTH=32, compared against the reference model a±b -> result, cout and v all match, and every done pulse is exactly 1 cycle wide.
